// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state encoding and requester IDs for the memory arbiter
package mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 28;
  localparam int BLOCK_W_DEF = 128;
  localparam int TIMEOUT_DEF = 1023;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_t;
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: per-transaction grant cycle counter with a sticky timeout flag
module mem_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout,
  output logic err
);
  logic [9:0] cnt;
  // fires in the grant cycle whose increment would bring the count to TIMEOUT
  assign timeout = en && cnt == 10'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= clr ? '0 : en ? cnt + 10'd1 : cnt;
      err <= err | timeout;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: alternating two-cache arbiter for the shared main-memory block port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ICACHE_READ,
  input  logic [ADDR_W-1:0]  ICACHE_ADDRESS,
  output logic [BLOCK_W-1:0] ICACHE_READDATA,
  output logic               ICACHE_BUSYWAIT,
  input  logic               DCACHE_READ,
  input  logic               DCACHE_WRITE,
  input  logic [ADDR_W-1:0]  DCACHE_ADDRESS,
  input  logic [BLOCK_W-1:0] DCACHE_WRITEDATA,
  output logic [BLOCK_W-1:0] DCACHE_READDATA,
  output logic               DCACHE_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic               ERR
);
  state_t state;
  logic last_grant, seen_busy, op_read, op_write;
  logic req_i, req_d, pick_d, grant, complete, timeout;
  always_comb begin
    req_i = ICACHE_READ;
    req_d = DCACHE_READ | DCACHE_WRITE;
    pick_d = req_d & (~req_i | (last_grant == REQ_I));
    grant = (state == GRANT_I) || (state == GRANT_D);
    complete = grant & seen_busy & ~MEM_BUSYWAIT;
    MEM_READ = grant & op_read & ~complete;
    MEM_WRITE = grant & op_write & ~complete;
    ICACHE_BUSYWAIT = req_i & (state != DONE_I);
    DCACHE_BUSYWAIT = req_d & (state != DONE_D);
  end
  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk(CLK),
    .rst(RESET),
    .clr(state == IDLE),
    .en(grant),
    .timeout(timeout),
    .err(ERR)
  );
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      last_grant <= REQ_I;
      seen_busy <= 1'b0;
      op_read <= 1'b0;
      op_write <= 1'b0;
      MEM_ADDRESS <= '0;
      MEM_WRITEDATA <= '0;
      ICACHE_READDATA <= '0;
      DCACHE_READDATA <= '0;
    end else begin
      seen_busy <= grant & (seen_busy | MEM_BUSYWAIT);
      case (state)
        IDLE: if (req_i | req_d) begin
          state <= pick_d ? GRANT_D : GRANT_I;
          last_grant <= pick_d ? REQ_D : REQ_I;
          MEM_ADDRESS <= pick_d ? DCACHE_ADDRESS : ICACHE_ADDRESS;
          op_write <= pick_d & DCACHE_WRITE;
          op_read <= ~(pick_d & DCACHE_WRITE);
          if (pick_d) MEM_WRITEDATA <= DCACHE_WRITEDATA;
        end
        GRANT_I, GRANT_D: if (complete | timeout) begin
          state <= (state == GRANT_I) ? DONE_I : DONE_D;
          // a timed-out transaction leaves the previous block in place
          if (complete & op_read & (state == GRANT_I)) ICACHE_READDATA <= MEM_READDATA;
          if (complete & op_read & (state == GRANT_D)) DCACHE_READDATA <= MEM_READDATA;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random transactions checked against a transaction-level arbiter model
module tb_mem_arbiter;
  logic CLK = 1'b0, RESET = 1'b1;
  logic ICACHE_READ = 1'b0, DCACHE_READ = 1'b0, DCACHE_WRITE = 1'b0, MEM_BUSYWAIT = 1'b0;
  logic [27:0] ICACHE_ADDRESS = '0, DCACHE_ADDRESS = '0;
  logic [127:0] DCACHE_WRITEDATA = '0, MEM_READDATA = '0;
  logic [127:0] ICACHE_READDATA, DCACHE_READDATA, MEM_WRITEDATA;
  logic [27:0] MEM_ADDRESS;
  logic ICACHE_BUSYWAIT, DCACHE_BUSYWAIT, MEM_READ, MEM_WRITE, ERR;
  int checks = 0, errors = 0;
  bit last_d = 1'b0, exp_err = 1'b0;
  logic [127:0] exp_ird = '0, exp_drd = '0;

  mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .ICACHE_READ(ICACHE_READ), .ICACHE_ADDRESS(ICACHE_ADDRESS),
    .ICACHE_READDATA(ICACHE_READDATA), .ICACHE_BUSYWAIT(ICACHE_BUSYWAIT),
    .DCACHE_READ(DCACHE_READ), .DCACHE_WRITE(DCACHE_WRITE),
    .DCACHE_ADDRESS(DCACHE_ADDRESS), .DCACHE_WRITEDATA(DCACHE_WRITEDATA),
    .DCACHE_READDATA(DCACHE_READDATA), .DCACHE_BUSYWAIT(DCACHE_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // one complete transaction from IDLE; the winner follows from who asks and who went last
  task automatic txn(input int lat, input logic [127:0] data);
    bit ri, rd, w, ew;
    logic [27:0] ea;
    logic [127:0] ewd;
    #1;
    ri = ICACHE_READ;
    rd = DCACHE_READ | DCACHE_WRITE;
    w = (ri && rd) ? !last_d : rd;
    ea = w ? DCACHE_ADDRESS : ICACHE_ADDRESS;
    ew = w && DCACHE_WRITE;
    ewd = DCACHE_WRITEDATA;
    chk("idle_busy_i", 128'(ICACHE_BUSYWAIT), 128'(ri));
    chk("idle_busy_d", 128'(DCACHE_BUSYWAIT), 128'(rd));
    tick;
    last_d = w;
    ICACHE_ADDRESS = 28'($urandom);
    DCACHE_ADDRESS = 28'($urandom);
    DCACHE_WRITEDATA = rnd128();
    MEM_BUSYWAIT = 1'b1;
    #1;
    chk("grant_addr", 128'(MEM_ADDRESS), 128'(ea));
    chk("grant_read", 128'(MEM_READ), 128'(!ew));
    chk("grant_write", 128'(MEM_WRITE), 128'(ew));
    if (ew) chk("grant_wdata", MEM_WRITEDATA, ewd);
    chk("winner_stall", 128'(w ? DCACHE_BUSYWAIT : ICACHE_BUSYWAIT), 128'(1));
    chk("loser_stall", 128'(w ? ICACHE_BUSYWAIT : DCACHE_BUSYWAIT), 128'(w ? ri : rd));
    repeat (lat - 1) begin
      tick;
      chk("hold_addr", 128'(MEM_ADDRESS), 128'(ea));
      chk("hold_op", 128'({MEM_READ, MEM_WRITE}), 128'({!ew, ew}));
    end
    tick;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = data;
    #1;
    chk("complete_strobes", 128'({MEM_READ, MEM_WRITE}), 128'(0));
    tick;
    if (!ew) begin
      if (w) exp_drd = data;
      else exp_ird = data;
    end
    chk("done_release", 128'(w ? DCACHE_BUSYWAIT : ICACHE_BUSYWAIT), 128'(0));
    chk("done_strobes", 128'({MEM_READ, MEM_WRITE}), 128'(0));
    chk("i_rdata", ICACHE_READDATA, exp_ird);
    chk("d_rdata", DCACHE_READDATA, exp_drd);
    chk("err", 128'(ERR), 128'(exp_err));
    MEM_READDATA = rnd128();
    if (w) begin
      DCACHE_READ = 1'b0;
      DCACHE_WRITE = 1'b0;
    end else ICACHE_READ = 1'b0;
    tick;
  endtask

  initial begin
    repeat (2) tick;
    chk("rst_read", 128'(MEM_READ), 128'(0));
    chk("rst_write", 128'(MEM_WRITE), 128'(0));
    chk("rst_err", 128'(ERR), 128'(0));
    chk("rst_i_rdata", ICACHE_READDATA, 128'(0));
    chk("rst_d_rdata", DCACHE_READDATA, 128'(0));
    chk("rst_addr", 128'(MEM_ADDRESS), 128'(0));
    chk("rst_wdata", MEM_WRITEDATA, 128'(0));
    RESET = 1'b0;
    tick;
    ICACHE_READ = 1'b1;
    ICACHE_ADDRESS = 28'h0000010;
    txn(5, 128'h0123456789ABCDEF00000000DEADBEEF);
    chk("deadbeef", ICACHE_READDATA, 128'h0123456789ABCDEF00000000DEADBEEF);
    ICACHE_READ = 1'b1;
    ICACHE_ADDRESS = 28'h0001111;
    DCACHE_READ = 1'b1;
    DCACHE_ADDRESS = 28'h0002222;
    txn(2, rnd128());
    txn(3, rnd128());
    DCACHE_READ = 1'b1;
    DCACHE_ADDRESS = 28'h0003333;
    txn(1, rnd128());
    ICACHE_READ = 1'b1;
    ICACHE_ADDRESS = 28'h0004444;
    DCACHE_READ = 1'b1;
    DCACHE_ADDRESS = 28'h0005555;
    txn(2, rnd128());
    txn(2, rnd128());
    DCACHE_WRITE = 1'b1;
    DCACHE_ADDRESS = 28'h0006666;
    DCACHE_WRITEDATA = {4{32'hA5A5A5A5}};
    txn(4, rnd128());
    DCACHE_READ = 1'b1;
    DCACHE_WRITE = 1'b1;
    DCACHE_ADDRESS = 28'h0007777;
    txn(2, rnd128());
    ICACHE_READ = 1'b1;
    ICACHE_ADDRESS = 28'h0ABCDEF;
    tick;
    chk("to_first", 128'(MEM_READ), 128'(1));
    repeat (1022) tick;
    chk("to_last_read", 128'(MEM_READ), 128'(1));
    chk("to_last_err", 128'(ERR), 128'(0));
    chk("to_last_busy", 128'(ICACHE_BUSYWAIT), 128'(1));
    tick;
    exp_err = 1'b1;
    chk("to_done_busy", 128'(ICACHE_BUSYWAIT), 128'(0));
    chk("to_done_err", 128'(ERR), 128'(1));
    chk("to_done_read", 128'(MEM_READ), 128'(0));
    chk("to_rdata", ICACHE_READDATA, exp_ird);
    tick;
    chk("to_idle_busy", 128'(ICACHE_BUSYWAIT), 128'(1));
    ICACHE_READ = 1'b0;
    repeat (3) tick;
    chk("to_sticky", 128'(ERR), 128'(1));
    DCACHE_READ = 1'b1;
    DCACHE_ADDRESS = 28'h0008888;
    txn(3, rnd128());
    DCACHE_READ = 1'b1;
    DCACHE_ADDRESS = 28'h0F00F00;
    tick;
    MEM_BUSYWAIT = 1'b1;
    #1;
    chk("pre_rst_read", 128'(MEM_READ), 128'(1));
    #2;
    RESET = 1'b1;
    #1;
    exp_err = 1'b0;
    exp_ird = '0;
    exp_drd = '0;
    last_d = 1'b0;
    chk("arst_read", 128'(MEM_READ), 128'(0));
    chk("arst_write", 128'(MEM_WRITE), 128'(0));
    chk("arst_err", 128'(ERR), 128'(0));
    chk("arst_d_rdata", DCACHE_READDATA, 128'(0));
    chk("arst_d_busy", 128'(DCACHE_BUSYWAIT), 128'(1));
    MEM_BUSYWAIT = 1'b0;
    DCACHE_READ = 1'b0;
    tick;
    RESET = 1'b0;
    tick;
    ICACHE_READ = 1'b1;
    ICACHE_ADDRESS = 28'h0009999;
    DCACHE_READ = 1'b1;
    DCACHE_ADDRESS = 28'h000AAAA;
    txn(2, rnd128());
    txn(2, rnd128());
    for (int n = 0; n < 40; n++) begin
      if (!ICACHE_READ && $urandom_range(0, 1) == 1) begin
        ICACHE_READ = 1'b1;
        ICACHE_ADDRESS = 28'($urandom);
      end
      if (!DCACHE_READ && !DCACHE_WRITE && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0: DCACHE_READ = 1'b1;
          1: DCACHE_WRITE = 1'b1;
          default: begin
            DCACHE_READ = 1'b1;
            DCACHE_WRITE = 1'b1;
          end
        endcase
        DCACHE_ADDRESS = 28'($urandom);
        DCACHE_WRITEDATA = rnd128();
      end
      if (!ICACHE_READ && !DCACHE_READ && !DCACHE_WRITE) DCACHE_READ = 1'b1;
      txn(int'($urandom_range(1, 6)), rnd128());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single main-memory block port between the instruction cache (read-only refills) and the data cache (refills and write-backs).
- Sits between both caches and main memory in the CPU top level.
- Serialises block transfers and alternates grants under contention.
- Latches each transaction's address, operation and data so memory sees stable inputs.
- Runs a watchdog on every memory transaction.

Parameters:
ADDR_W, 28, block address width (word address bits above the block offset)
BLOCK_W, 128, block data width (4 x 32-bit words)
TIMEOUT, 1023, max cycles spent in a grant state before forced abort; the counter is 10 bits wide

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
ICACHE_READ  in  1  instruction cache block read request
ICACHE_ADDRESS  in  ADDR_W  instruction cache block address
ICACHE_READDATA  out  BLOCK_W  returned block (registered)
ICACHE_BUSYWAIT  out  1  stall to instruction cache
DCACHE_READ  in  1  data cache block read request
DCACHE_WRITE  in  1  data cache block write-back request
DCACHE_ADDRESS  in  ADDR_W  data cache block address
DCACHE_WRITEDATA  in  BLOCK_W  write-back block
DCACHE_READDATA  out  BLOCK_W  returned block (registered)
DCACHE_BUSYWAIT  out  1  stall to data cache
MEM_READ  out  1  main memory read strobe
MEM_WRITE  out  1  main memory write strobe
MEM_ADDRESS  out  ADDR_W  latched address
MEM_WRITEDATA  out  BLOCK_W  latched write data
MEM_READDATA  in  BLOCK_W  memory read data
MEM_BUSYWAIT  in  1  memory busy
ERR  out  1  sticky timeout flag

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D.
- Reset (async, any state, mid-transaction included):
  - State goes to IDLE; last_grant=I, so D wins the first contention.
  - seen_busy=0, wait counter=0, ERR=0.
  - Latched address/data/op registers and both READDATA registers are 0.
  - MEM_READ and MEM_WRITE are 0 immediately.
- Request definitions: req_i=ICACHE_READ; req_d=DCACHE_READ|DCACHE_WRITE. When DCACHE_READ and DCACHE_WRITE are both high, the op is a write.
- IDLE:
  - Only one requester asserting: that requester is chosen.
  - Both asserting: the requester other than last_grant is chosen.
  - On the clock edge, latch that requester's address and op (and DCACHE_WRITEDATA for D), set last_grant, clear seen_busy and the counter, and enter GRANT_x.
  - No request: stay in IDLE.
- GRANT_x:
  - MEM_READ/MEM_WRITE are driven from the latched op; MEM_ADDRESS/MEM_WRITEDATA come from the latched registers. Requester input changes are ignored.
  - seen_busy is set on any cycle with MEM_BUSYWAIT=1.
  - Completion: seen_busy=1 and MEM_BUSYWAIT=0, evaluated combinationally.
  - MEM_READ and MEM_WRITE are forced to 0 in the completion cycle.
  - On the completion edge: for a read, latch MEM_READDATA into x's READDATA register; then enter DONE_x.
  - Counter increments every GRANT cycle. On reaching TIMEOUT: set ERR (sticky), leave READDATA unchanged, enter DONE_x.
- DONE_x:
  - Lasts exactly one cycle; MEM strobes are 0.
  - x's BUSYWAIT is 0 so the cache consumes its READDATA.
  - Next state is IDLE.
- BUSYWAIT_x = req_x AND NOT(state==DONE_x), combinational.
  - It rises in the same cycle a request appears.
  - The loser of arbitration stays stalled through the whole transaction of the other requester.
- A request still asserted in IDLE after DONE counts as a new transaction. The caches drop or change their request at the DONE edge.
- Latency: an uncontended request reaches memory 1 cycle after assertion. Its BUSYWAIT drops 1 cycle after memory completion.
- Back-to-back D write-back followed by refill:
  - If I is also pending, I is served between them.
  - Each transaction returns to IDLE before the next grant; there is no cycle where both MEM strobes are 1.
- MEM_ADDRESS and MEM_WRITEDATA hold their last value outside GRANT.
- DCACHE_READDATA is not modified by a write transaction.

Decomposition:
- Shared package: state encoding constants (IDLE=0, GRANT_I=1, GRANT_D=2, DONE_I=3, DONE_D=4, 3-bit), requester ID constants (REQ_I=0, REQ_D=1), and the ADDR_W and BLOCK_W defaults.
- One sub-module: mem_watchdog. It holds the 10-bit counter with clear/enable inputs and a timeout output, plus the sticky ERR register.
- The FSM, latches and output muxing stay in mem_arbiter.

Test Plan:
1. Only ICACHE_READ, addr 0x0000010, memory busy for 5 cycles then data 0x...DEADBEEF → MEM_READ=1 from cycle+1; ICACHE_BUSYWAIT=0 one cycle after busy falls; ICACHE_READDATA=0x...DEADBEEF.
2. DCACHE_READ and ICACHE_READ asserted in the same cycle after reset → D granted first (MEM_ADDRESS=D addr), then I. In a repeat contention, I is granted first (alternation).
3. DCACHE_WRITE with WRITEDATA=0xA5A5..., while requester changes address/data during GRANT → MEM_ADDRESS and MEM_WRITEDATA stay at the latched values; DCACHE_READDATA is unchanged; MEM_READ stays 0.
4. DCACHE_READ and DCACHE_WRITE both high → MEM_WRITE=1, MEM_READ=0.
5. RESET asserted asynchronously mid-GRANT_D, between clock edges → MEM_READ/MEM_WRITE go to 0 immediately; state is IDLE; ERR=0; the next contention grants D first.
6. Memory never asserts MEM_BUSYWAIT → after 1023 GRANT cycles ERR=1, the requester's BUSYWAIT drops for one cycle, and ERR stays 1 until RESET.
